// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample ratio, default
// line parameters (50 MHz clock, 19200 baud, 8N1) used by both TX and RX.
// No ports; no logic.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_DVSR    = 163;
  localparam int DEF_DVSR_W  = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: counts 0..DVSR-1, s_tick_o high on DVSR-1.
// Latency: s_tick_o is combinational from the count register; clr_i lands next edge.
// Backpressure: none; free-running.  Ports: clk, reset, clr_i (sync clear), s_tick_o.
module uart_baud_gen #(
  parameter int DVSR   = uart_pkg::DEF_DVSR,
  parameter int DVSR_W = uart_pkg::DEF_DVSR_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic s_tick_o
);

  localparam logic [DVSR_W-1:0] LAST = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + DVSR_W'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign s_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a first-word fall-through FIFO: pops a byte when idle,
// sends start, DBIT data bits LSB first, then SB_TICK oversample ticks of stop.
// Latency: tx goes low one edge after the pop. Backpressure: pops only in IDLE.
// Ports: clk/reset; fifo_empty_i, fifo_rdata_i in; fifo_rd_o, tx_o, tx_busy_o,
// tx_done_tick_o out.
module uart_tx_fifo_drain #(
  parameter int DBIT    = uart_pkg::DEF_DBIT,
  parameter int SB_TICK = uart_pkg::DEF_SB_TICK,
  parameter int DVSR    = uart_pkg::DEF_DVSR,
  parameter int DVSR_W  = uart_pkg::DEF_DVSR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty_i,
  input  logic [DBIT-1:0] fifo_rdata_i,
  output logic            fifo_rd_o,
  output logic            tx_o,
  output logic            tx_busy_o,
  output logic            tx_done_tick_o
);

  import uart_pkg::*;

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Tick counter is 4 bits for a normal bit cell; it only widens when the
  // stop period is longer than one bit (1.5 / 2 stop bits).
  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            rd;
  logic            s_tick;

  // Cleared on the pop so the first tick lands exactly DVSR clocks after tx falls.
  uart_baud_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (rd),
    .s_tick_o (s_tick)
  );

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    done_d  = 1'b0;
    rd      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty_i && !reset) begin
          rd      = 1'b1;
          b_d     = fifo_rdata_i;
          s_cnt_d = '0;
          n_cnt_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            b_d     = b_q >> 1;
            if (n_cnt_q == N_LAST) begin
              n_cnt_d = '0;
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            s_cnt_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered, so tx is a clean flop output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_o      = rd;
  assign tx_o           = tx_q;
  assign tx_busy_o      = (state_q != IDLE);
  assign tx_done_tick_o = done_q;

endmodule
